// File: rtl/rom_sequencer_pkg.sv
// rom_sequencer_pkg: shared types and constants for the BCD balance micro-sequencer
package rom_sequencer_pkg;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_CARRY, S_DONE} state_t;
  typedef enum logic [1:0] {OP_NOP, OP_ADD, OP_CLR, OP_END} op_t;
  typedef enum logic [1:0] {D_ONES, D_TENS, D_HUNDREDS} dig_t;
  localparam logic [2:0] ROM_ADD1   = 3'd0;
  localparam logic [2:0] ROM_ADD10  = 3'd1;
  localparam logic [2:0] ROM_ADD100 = 3'd2;
  localparam logic [2:0] ROM_RESET  = 3'd3;
  localparam logic [2:0] ROM_NONE   = 3'd4;
  typedef struct packed {
    op_t  op;
    dig_t dig;
  } uword_t;
endpackage

// File: rtl/rom_program.sv
// rom_program: combinational micro-ROM, one micro-word per (program id, pc)
//   i_id  : program id (0 add-one, 1 add-ten, 2 add-hundred, 3 reset-balance)
//   i_pc  : program counter
//   o_uw  : micro-word (opcode + digit select)
module rom_program
  import rom_sequencer_pkg::*;
(
  input  logic [1:0] i_id,
  input  logic [1:0] i_pc,
  output uword_t     o_uw
);
  // Every program is a single operation followed by END; unused slots are NOP
  always_comb begin
    o_uw.op  = i_pc == 2'd0 ? (i_id == ROM_RESET[1:0] ? OP_CLR : OP_ADD)
             : i_pc == 2'd1 ? OP_END : OP_NOP;
    o_uw.dig = i_id == ROM_RESET[1:0] ? D_ONES : dig_t'(i_id);
  end
endmodule

// File: rtl/rom_sequencer.sv
// rom_sequencer: key-driven micro-programmed BCD balance counter (000-999)
//   clk                  : clock, rising edge
//   reset                : asynchronous active-high reset
//   rom_num              : program request (0..3 valid, 4..7 no request)
//   ones/tens/hundreds   : BCD balance digits
//   busy                 : program executing
//   done                 : one-cycle completion pulse
//   overflow             : one-cycle pulse when an add is rejected
module rom_sequencer
  import rom_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] rom_num,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic [3:0] hundreds,
  output logic       busy,
  output logic       done,
  output logic       overflow
);
  state_t     r_state, w_nstate;
  logic [1:0] r_pc, w_npc, r_id, w_nid;
  dig_t       r_tgt, w_ntgt;
  logic [3:0] r_dig [3];
  logic [3:0] w_ndig [3];
  logic       r_armed, w_noreq, w_accept, w_sat, w_ovf;
  uword_t     w_uw;

  rom_program u_rom (.i_id(r_id), .i_pc(r_pc), .o_uw(w_uw));

  assign w_noreq  = rom_num >= ROM_NONE;
  assign w_accept = r_state == S_IDLE && !w_noreq && r_armed;
  // Selected digit and every higher digit at 9: the add cannot fit in 999
  assign w_sat = (w_uw.dig != D_ONES || r_dig[0] == 4'd9)
              && (w_uw.dig == D_HUNDREDS || r_dig[1] == 4'd9)
              && r_dig[2] == 4'd9;

  always_comb begin
    w_nstate = r_state;
    w_npc    = r_pc;
    w_nid    = r_id;
    w_ntgt   = r_tgt;
    w_ndig   = r_dig;
    w_ovf    = 1'b0;
    case (r_state)
      S_IDLE: if (w_accept) begin
        w_nstate = S_EXEC;
        w_npc    = 2'd0;
        w_nid    = rom_num[1:0];
      end
      S_EXEC: begin
        w_npc = r_pc + 2'd1;
        if (w_uw.op == OP_END || r_pc == 2'd3) begin
          w_nstate = S_DONE;
          w_npc    = r_pc;
        end else if (w_uw.op == OP_CLR)
          w_ndig = '{4'd0, 4'd0, 4'd0};
        else if (w_uw.op == OP_ADD && w_sat)
          w_ovf = 1'b1;
        else if (w_uw.op == OP_ADD && r_dig[w_uw.dig] != 4'd9)
          w_ndig[w_uw.dig] = r_dig[w_uw.dig] + 4'd1;
        else if (w_uw.op == OP_ADD) begin
          w_ndig[w_uw.dig] = 4'd0;
          w_ntgt   = dig_t'(w_uw.dig + 2'd1);
          w_nstate = S_CARRY;
          w_npc    = r_pc;
        end
      end
      S_CARRY: begin
        // Saturation was ruled out before entering, so the carry always lands
        w_ndig[r_tgt] = r_dig[r_tgt] == 4'd9 ? 4'd0 : r_dig[r_tgt] + 4'd1;
        w_ntgt   = r_dig[r_tgt] == 4'd9 ? dig_t'(r_tgt + 2'd1) : r_tgt;
        w_nstate = r_dig[r_tgt] == 4'd9 ? S_CARRY : S_EXEC;
        w_npc    = r_dig[r_tgt] == 4'd9 ? r_pc : r_pc + 2'd1;
      end
      default: w_nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_pc    <= 2'd0;
      r_id    <= 2'd0;
      r_tgt   <= D_ONES;
      r_dig   <= '{4'd0, 4'd0, 4'd0};
      r_armed <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_pc    <= w_npc;
      r_id    <= w_nid;
      r_tgt   <= w_ntgt;
      r_dig   <= w_ndig;
      r_armed <= w_accept ? 1'b0 : (w_noreq ? 1'b1 : r_armed);
    end
  end

  assign ones     = r_dig[0];
  assign tens     = r_dig[1];
  assign hundreds = r_dig[2];
  assign busy     = r_state != S_IDLE;
  assign done     = r_state == S_DONE;
  assign overflow = w_ovf;
endmodule

// File: tb/tb_rom_sequencer.sv
// tb_rom_sequencer: directed stimulus with a decimal-arithmetic reference model
module tb_rom_sequencer;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] rom_num = 3'd0;
  logic [3:0] ones, tens, hundreds;
  logic       busy, done, overflow;

  int n_vec = 0;
  int n_err = 0;

  rom_sequencer dut (
    .clk(clk), .reset(reset), .rom_num(rom_num),
    .ones(ones), .tens(tens), .hundreds(hundreds),
    .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int pw [3] = '{1, 10, 100};
  int m_bal = 0, m_res = 0, m_t = 0, m_len = 3;
  bit m_ovf = 1'b0, m_armed = 1'b0;

  function automatic logic [11:0] bcd(input int b);
    return {4'(b / 100), 4'((b / 10) % 10), 4'(b % 10)};
  endfunction

  // Model: balance as an integer; a program's length is 3 cycles plus one
  // per run of 9s starting at the added digit
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_bal = 0; m_t = 0; m_armed = 1'b0; m_ovf = 1'b0;
    end else begin
      if (m_t > 0) begin
        if (m_t == m_len) begin
          m_t = 0;
          m_bal = m_res;
        end else m_t++;
      end else if (rom_num < 4 && m_armed) begin
        m_armed = 1'b0;
        m_t = 1;
        m_len = 3;
        m_ovf = 1'b0;
        if (rom_num == 3) m_res = 0;
        else if (m_bal + pw[rom_num] > 999) begin
          m_res = m_bal;
          m_ovf = 1'b1;
        end else begin
          m_res = m_bal + pw[rom_num];
          for (int d = int'(rom_num); d < 3 && (m_bal / pw[d]) % 10 == 9; d++) m_len++;
        end
      end
      if (rom_num >= 4) m_armed = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      logic eb, ed, eo;
      logic [11:0] ebal;
      eb = m_t > 0;
      ed = m_t > 0 && m_t == m_len;
      eo = m_t == 1 && m_ovf;
      n_vec++;
      if (busy !== eb || done !== ed || overflow !== eo) begin
        n_err++;
        $display("FAIL ctrl t=%0t busy/done/ovf=%b%b%b exp=%b%b%b", $time, busy, done, overflow, eb, ed, eo);
      end
      if (!eb || ed) begin
        ebal = bcd(ed ? m_res : m_bal);
        n_vec++;
        if ({hundreds, tens, ones} !== ebal) begin
          n_err++;
          $display("FAIL balance t=%0t got=%h exp=%h", $time, {hundreds, tens, ones}, ebal);
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic press(input logic [2:0] k, input int hold, input logic [2:0] aft,
                       output int lat, output int ovf_at);
    lat = -1;
    ovf_at = -1;
    @(negedge clk) rom_num = k;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == hold) rom_num = aft;
      if (overflow) ovf_at = c;
      if (done) begin
        lat = c;
        break;
      end
    end
    if (lat < 0) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout waiting for done, key=%0d", k);
    end
    rom_num = 3'd4;
    @(negedge clk);
  endtask

  task automatic add_n(input logic [2:0] k, input int n);
    int l, o;
    repeat (n) press(k, 1, 3'd4, l, o);
  endtask

  initial begin
    int lat, ovf_at, dones;
    repeat (2) @(negedge clk);
    chk("reset_bal", {hundreds, tens, ones}, 12'h000);
    chk("reset_ctl", {busy, done, overflow}, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk) chk("held_key_after_reset", busy, 0);
    rom_num = 3'd4;
    @(negedge clk);
    press(3'd0, 1, 3'd4, lat, ovf_at);
    chk("add1_lat", lat, 3);
    chk("add1_bal", {hundreds, tens, ones}, 12'h001);
    add_n(3'd0, 8);
    press(3'd0, 1, 3'd4, lat, ovf_at);
    chk("carry1_lat", lat, 4);
    chk("carry1_bal", {hundreds, tens, ones}, 12'h010);
    add_n(3'd1, 8);
    add_n(3'd0, 9);
    press(3'd0, 1, 3'd4, lat, ovf_at);
    chk("carry2_lat", lat, 5);
    chk("carry2_bal", {hundreds, tens, ones}, 12'h100);
    add_n(3'd2, 8);
    add_n(3'd1, 9);
    add_n(3'd0, 9);
    chk("bal_999", {hundreds, tens, ones}, 12'h999);
    press(3'd1, 1, 3'd4, lat, ovf_at);
    chk("ovf_at", ovf_at, 1);
    chk("ovf_lat", lat, 3);
    chk("ovf_bal", {hundreds, tens, ones}, 12'h999);
    press(3'd3, 1, 3'd4, lat, ovf_at);
    add_n(3'd2, 4);
    add_n(3'd1, 5);
    add_n(3'd0, 7);
    chk("bal_457", {hundreds, tens, ones}, 12'h457);
    press(3'd3, 1, 3'd4, lat, ovf_at);
    chk("clr_lat", lat, 3);
    chk("clr_bal", {hundreds, tens, ones}, 12'h000);
    @(negedge clk) rom_num = 3'd0;
    dones = 0;
    repeat (20) @(negedge clk) if (done) dones++;
    rom_num = 3'd4;
    @(negedge clk);
    chk("held_key_dones", dones, 1);
    chk("held_key_bal", {hundreds, tens, ones}, 12'h001);
    repeat (3) @(negedge clk) begin
      rom_num = 3'd6;
      chk("code6_idle", busy, 0);
    end
    press(3'd0, 1, 3'd2, lat, ovf_at);
    chk("busy_key_lat", lat, 3);
    chk("busy_key_bal", {hundreds, tens, ones}, 12'h002);
    press(3'd3, 1, 3'd4, lat, ovf_at);
    add_n(3'd1, 9);
    add_n(3'd0, 9);
    @(negedge clk) rom_num = 3'd0;
    @(negedge clk);
    @(negedge clk);
    chk("in_carry_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_bal", {hundreds, tens, ones}, 12'h000);
    chk("async_reset_busy", busy, 0);
    @(negedge clk);
    @(negedge clk) reset = 1'b0;
    repeat (3) @(negedge clk) chk("held_after_reset", busy, 0);
    rom_num = 3'd4;
    @(negedge clk);
    press(3'd0, 1, 3'd4, lat, ovf_at);
    chk("post_reset_lat", lat, 3);
    chk("post_reset_bal", {hundreds, tens, ones}, 12'h001);
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/rom_sequencer.md
ROM_SEQUENCER -- requirements
Module: rom_sequencer

Interface
REQ-001 SHALL have port clk, input, 1, sole clock, all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port rom_num, input, 3, program select from the key encoder: 0 add-one, 1 add-ten, 2 add-hundred, 3 reset-balance, 4 no request; 5-7 treated as 4.
REQ-004 SHALL have port ones, output, 4, BCD ones digit of balance.
REQ-005 SHALL have port tens, output, 4, BCD tens digit of balance.
REQ-006 SHALL have port hundreds, output, 4, BCD hundreds digit of balance.
REQ-007 SHALL have port busy, output, 1, high while a program executes (state != IDLE).
REQ-008 SHALL have port done, output, 1, one-cycle pulse on program completion.
REQ-009 SHALL have port overflow, output, 1, one-cycle pulse when an add is rejected.

Function
REQ-010 SHALL implement states IDLE, EXEC, CARRY, DONE.
REQ-011 SHALL keep an armed flag, set in any cycle rom_num is no-request, cleared on program acceptance.
REQ-012 IDLE: SHALL accept when rom_num in 0..3 and armed; latch program id, pc=0, go EXEC next cycle.
REQ-013 SHALL ignore rom_num while busy; a key held across completion SHALL NOT retrigger (armed still clear).
REQ-014 SHALL fetch one micro-word per EXEC cycle from program (id, pc); opcodes NOP, ADD(digit), CLR, END.
REQ-015 Program contents: 0 = ADD ones, END; 1 = ADD tens, END; 2 = ADD hundreds, END; 3 = CLR, END.
REQ-016 NOP: pc+1. CLR: all digits 0, pc+1. END: go DONE.
REQ-017 ADD: overflow iff selected digit and every higher digit equal 9; then balance unchanged, overflow pulses that cycle, pc+1.
REQ-018 ADD without overflow: selected digit <9 -> digit+1, pc+1; digit =9 -> digit=0, carry target = next higher digit, go CARRY.
REQ-019 CARRY: one cycle per digit; target <9 -> +1, return EXEC with pc+1; target =9 -> 0, carry target moves up one, stay CARRY.
REQ-020 DONE: done=1 for exactly that cycle, go IDLE next cycle.
REQ-021 Latency from accept cycle T: no carry -> done at T+3; each carry step adds one cycle.
REQ-022 Balance SHALL always be valid BCD 000-999; no digit ever exceeds 9.
REQ-023 pc SHALL be 2 bits; reaching pc=3 without END SHALL be treated as END.

Reset
REQ-024 reset SHALL asynchronously force IDLE, ones=tens=hundreds=0, busy=0, done=0, overflow=0, pc=0, armed=0.
REQ-025 reset mid-EXEC/CARRY SHALL abandon the program; partial carries discarded, balance 000.
REQ-026 After reset release, a key already held SHALL NOT execute until rom_num returns to 4.

Structure
REQ-027 Shared package SHALL hold: state enum, opcode enum, digit-select enum, ROM_NONE=4, ROM_ADD1/ADD10/ADD100/RESET constants, micro-word typedef.
REQ-028 Micro-ROM SHALL be a separate combinational sub-module rom_program (inputs program id, pc; output micro-word).
REQ-029 Digit registers, FSM, armed flag SHALL live in rom_sequencer.

Verification
REQ-030 Balance 000, rom_num 4->0 one cycle ->4 -> ones=1, done pulse at T+3, busy T+1..T+3.
REQ-031 Balance 009, add-one -> 010, one CARRY cycle, done at T+4.
REQ-032 Balance 999, add-ten -> overflow pulse, balance 999, done at T+3; 099 add-one -> 100, done T+5.
REQ-033 Balance 457, rom_num=3 -> 000; rom_num held 0 for 20 cycles -> exactly one add, one done.
REQ-034 Balance 099 add-one, reset asserted during CARRY -> 000 immediately, busy=0; held key post-reset ignored until released.
REQ-035 rom_num=6 in IDLE -> no execution, arms flag; rom_num 2 while busy -> ignored.
